// File: rtl/vo_table_stream.sv
// Writable vocal-parameter table: self-initialises after reset, then streams single words or wrapping bursts.
// Optional running burst sum on sum_out/sum_valid when VO_BURST_SUM_EN is defined.
module vo_table_stream #(
  parameter int unsigned    DW        = 8,
  parameter int unsigned    AW        = 8,
  parameter logic [DW-1:0]  INIT_VAL  = DW'(8'h2),
  parameter logic [DW-1:0]  INIT_VAL0 = DW'(8'h0)
) (
  input  logic          CS,
  input  logic          cen,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  input  logic [AW-1:0] rd_len,
  output logic [DW-1:0] Vop,
  output logic          vop_valid,
  input  logic          vop_ready,
  output logic          vop_last,
  output logic          init_done
`ifdef VO_BURST_SUM_EN
  ,
  output logic [DW-1:0] sum_out,
  output logic          sum_valid
`endif
);

  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] init_ptr_q, init_ptr_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] vop_q, vop_d;
  logic          vop_valid_q, vop_valid_d;
  logic          vop_last_q, vop_last_d;
  logic          init_done_q, init_done_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rd_word;

`ifdef VO_BURST_SUM_EN
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] sum_hold_q, sum_hold_d;
`endif

  assign rd_word = mem_q[ptr_q];

  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    vop_d       = vop_q;
    vop_valid_d = vop_valid_q;
    vop_last_d  = vop_last_q;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_data;
`ifdef VO_BURST_SUM_EN
    acc_d       = acc_q;
    sum_hold_d  = sum_hold_q;
`endif
    case (state_q)
      S_INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_ptr_q;
        mem_wdata  = (init_ptr_q == '0) ? INIT_VAL0 : INIT_VAL;
        init_ptr_d = init_ptr_q + AW'(1);
        if (init_ptr_q == '1) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        mem_we = wr_en;
        // A word left over from the previous burst still drains here
        if (vop_valid_q && vop_ready) vop_valid_d = 1'b0;
        if (rd_valid) begin
          ptr_d   = rd_addr;
          cnt_d   = (rd_len == '0) ? AW'(1) : rd_len;
          state_d = S_BURST;
`ifdef VO_BURST_SUM_EN
          acc_d   = '0;
`endif
        end
      end
      S_BURST: begin
        mem_we = wr_en;
        if (!vop_valid_q || vop_ready) begin
          // rd_word is sampled before this edge's write lands: read-before-write
          vop_d       = rd_word;
          vop_valid_d = 1'b1;
          vop_last_d  = (cnt_q == AW'(1));
          ptr_d       = ptr_q + AW'(1);
          cnt_d       = cnt_q - AW'(1);
`ifdef VO_BURST_SUM_EN
          acc_d       = acc_q + rd_word;
          if (cnt_q == AW'(1)) sum_hold_d = acc_q + rd_word;
`endif
          if (cnt_q == AW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge CS or negedge cen) begin
    if (!cen) begin
      state_q     <= S_INIT;
      init_ptr_q  <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      vop_q       <= '0;
      vop_valid_q <= 1'b0;
      vop_last_q  <= 1'b0;
      init_done_q <= 1'b0;
`ifdef VO_BURST_SUM_EN
      acc_q       <= '0;
      sum_hold_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      vop_q       <= vop_d;
      vop_valid_q <= vop_valid_d;
      vop_last_q  <= vop_last_d;
      init_done_q <= init_done_d;
`ifdef VO_BURST_SUM_EN
      acc_q       <= acc_d;
      sum_hold_q  <= sum_hold_d;
`endif
    end
  end

  // Table storage is deliberately outside the reset domain
  always_ff @(posedge CS) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_ready  = (state_q == S_IDLE);
  assign Vop       = vop_q;
  assign vop_valid = vop_valid_q;
  assign vop_last  = vop_last_q;
  assign init_done = init_done_q;

`ifdef VO_BURST_SUM_EN
  assign sum_valid = vop_valid_q && vop_ready && vop_last_q;
  assign sum_out   = sum_valid ? sum_hold_q : '0;
`endif

endmodule

// File: tb/tb_vo_table_stream.sv
// Scoreboard bench for vo_table_stream: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_vo_table_stream;

  logic       CS = 1'b0;
  logic       cen;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_addr;
  logic [7:0] rd_len;
  logic [7:0] Vop;
  logic       vop_valid;
  logic       vop_ready;
  logic       vop_last;
  logic       init_done;
`ifdef VO_BURST_SUM_EN
  logic [7:0] sum_out;
  logic       sum_valid;
`endif

  vo_table_stream #(.DW(8), .AW(8), .INIT_VAL(8'h2), .INIT_VAL0(8'h0)) dut (
    .CS(CS), .cen(cen), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_len(rd_len),
    .Vop(Vop), .vop_valid(vop_valid), .vop_ready(vop_ready), .vop_last(vop_last),
    .init_done(init_done)
`ifdef VO_BURST_SUM_EN
    , .sum_out(sum_out), .sum_valid(sum_valid)
`endif
  );

  always #5 CS = ~CS;

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CS);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic request(input logic [7:0] a, input logic [7:0] len);
    int n = 0;
    while (!rd_ready && n < 100) begin tick(); n++; end
    if (!rd_ready) chk(1'b0, "rd_ready_timeout", 32'(rd_ready), 32'd1);
    rd_valid = 1'b1; rd_addr = a; rd_len = len;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic drain(input logic [3:0] pat);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !vop_valid) break;
      vop_ready = pat[i % 4];
      tick();
    end
    if (sb.size() != 0 || vop_valid) chk(1'b0, "drain_timeout", 32'(sb.size()), 32'd0);
    vop_ready = 1'b1;
  endtask

  // Monitor: compares every handshake against the scoreboard and checks stalled words stay put
  logic       stall_prev = 1'b0;
  logic [7:0] held;
  logic       held_last;
  logic [7:0] run_sum = '0;

  always @(negedge CS) begin
    exp_t e;
    if (!cen) begin
      stall_prev = 1'b0;
      run_sum    = '0;
    end else begin
      if (stall_prev)
        chk(vop_valid && Vop == held && vop_last == held_last, "hold",
            {22'd0, vop_valid, vop_last, Vop}, {22'd0, 1'b1, held_last, held});
      if (vop_valid && vop_ready) begin
        if (sb.size() == 0) chk(1'b0, "unexpected_word", 32'(Vop), 32'd0);
        else begin
          e = sb.pop_front();
          chk(Vop == e.d, "vop_data", 32'(Vop), 32'(e.d));
          chk(vop_last == e.l, "vop_last", 32'(vop_last), 32'(e.l));
          run_sum = run_sum + e.d;
`ifdef VO_BURST_SUM_EN
          chk(sum_valid == e.l, "sum_valid", 32'(sum_valid), 32'(e.l));
          if (e.l) chk(sum_out == run_sum, "sum_out", 32'(sum_out), 32'(run_sum));
`endif
          if (e.l) run_sum = '0;
        end
      end
      stall_prev = vop_valid && !vop_ready;
      held       = Vop;
      held_last  = vop_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cen = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; rd_len = '0; vop_ready = 1'b1;
    tick(); tick();
    chk(!vop_valid && Vop == 8'h00 && !vop_last, "reset_outputs", {23'd0, vop_valid, Vop}, 32'd0);
    chk(!rd_ready && !init_done, "reset_ctrl", {30'd0, rd_ready, init_done}, 32'd0);

    // Init: init_done rises on exactly the 256th edge after release
    cen = 1'b1;
    repeat (255) tick();
    chk(init_done == 1'b0, "init_done_255", 32'(init_done), 32'd0);
    tick();
    chk(init_done == 1'b1, "init_done_256", 32'(init_done), 32'd1);
    chk(rd_ready == 1'b1, "rd_ready_idle", 32'(rd_ready), 32'd1);

    push(8'h00, 1'b1);
    request(8'd0, 8'd1);
    drain(4'b1111);
    push(8'h02, 1'b0); push(8'h02, 1'b0); push(8'h02, 1'b1);
    request(8'd5, 8'd3);
    drain(4'b1111);
    push(8'h02, 1'b1);
    request(8'd40, 8'd0);
    drain(4'b1111);

    // Write/read with latency check
    wr(8'd10, 8'hA5);
    wr(8'd11, 8'h3C);
    push(8'hA5, 1'b0); push(8'h3C, 1'b1);
    request(8'd10, 8'd2);
    chk(vop_valid == 1'b0, "latency_pre", 32'(vop_valid), 32'd0);
    tick();
    chk(vop_valid && Vop == 8'hA5, "latency_first", {23'd0, vop_valid, Vop}, {23'd0, 1'b1, 8'hA5});
    drain(4'b1111);

    // Wrap with backpressure (ready 1,0,0,1 repeating)
    wr(8'd255, 8'h77);
    push(8'h02, 1'b0); push(8'h77, 1'b0); push(8'h00, 1'b0); push(8'h02, 1'b1);
    request(8'd254, 8'd4);
    drain(4'b1001);

    // Collision: write addr 20 on the edge that issues addr 20
    vop_ready = 1'b1;
    push(8'h02, 1'b0); push(8'h02, 1'b0); push(8'h02, 1'b0); push(8'h02, 1'b1);
    request(8'd18, 8'd4);
    tick(); tick();
    wr(8'd20, 8'h55);
    drain(4'b1111);
    push(8'h55, 1'b1);
    request(8'd20, 8'd1);
    drain(4'b1111);

`ifdef VO_BURST_SUM_EN
    wr(8'd30, 8'h01);
    wr(8'd31, 8'hFF);
    wr(8'd32, 8'h10);
    push(8'h01, 1'b0); push(8'hFF, 1'b0); push(8'h10, 1'b1);
    request(8'd30, 8'd3);
    drain(4'b1111);
`endif

    // Reset mid-burst: abort on the 3rd word, then re-init overwrites addr 10
    vop_ready = 1'b1;
    push(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) push(8'h02, 1'b0);
    push(8'h02, 1'b1);
    request(8'd0, 8'd10);
    tick(); tick(); tick();
    chk(vop_valid == 1'b1, "third_word_valid", 32'(vop_valid), 32'd1);
    cen = 1'b0;
    sb.delete();
    #1;
    chk(!vop_valid && Vop == 8'h00, "abort_outputs", {23'd0, vop_valid, Vop}, 32'd0);
    chk(init_done == 1'b0, "abort_init_done", 32'(init_done), 32'd0);
    tick(); tick();
    cen = 1'b1;
    repeat (255) tick();
    chk(init_done == 1'b0, "reinit_255", 32'(init_done), 32'd0);
    tick();
    chk(init_done == 1'b1, "reinit_256", 32'(init_done), 32'd1);
    push(8'h02, 1'b1);
    request(8'd10, 8'd1);
    drain(4'b1111);

    tick(); tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
